// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer-type, burst and size encodings
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;
  typedef enum logic [2:0] {SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
                            WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7} hburst_e;
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: first requester after last_i in circular order, last_i itself checked last
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] next_o,
  output logic          valid_o
);
  int j;
  // scan from farthest to nearest so the nearest requester after last_i wins
  always_comb begin
    next_o  = last_i;
    valid_o = |req_i;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = int'(last_i) + k;
      j = (j >= N) ? j - N : j;
      if (req_i[j[IW-1:0]]) next_o = j[IW-1:0];
    end
  end
endmodule

// File: rtl/ahb_lite_bus_arbiter.sv
// ahb_lite_bus_arbiter: round-robin AHB-Lite master multiplexer with separate data-phase owner; ARB_LOCK_EN enables HMASTLOCK-based locking
module ahb_lite_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int HOLD_MAX    = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_MASTERS-1:0]        m_req,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  input  logic [2*NUM_MASTERS-1:0]      m_htrans,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [3*NUM_MASTERS-1:0]      m_hsize,
  input  logic [3*NUM_MASTERS-1:0]      m_hburst,
  input  logic [NUM_MASTERS-1:0]        m_hmastlock,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_hwdata,
  output logic                          m_hready,
  output logic [NUM_MASTERS-1:0]        m_hresp,
  output logic [DATA_W-1:0]             m_hrdata,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic                          HMASTLOCK,
  output logic [DATA_W-1:0]             HWDATA,
  input  logic                          HREADY,
  input  logic                          HRESP,
  input  logic [DATA_W-1:0]             HRDATA
);
  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  logic [IW-1:0] addr_owner_q, addr_owner_d, data_owner_q, nxt;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          data_vld_q, pick_vld, locked, single_ns, sw, chg;
  logic [1:0]    own_trans;
  logic [2:0]    own_burst;
  ahb_rr_picker #(.N(N)) u_pick (
    .req_i   (m_req),
    .last_i  (addr_owner_q),
    .next_o  (nxt),
    .valid_o (pick_vld)
  );
  assign own_trans = m_htrans[2*addr_owner_q +: 2];
  assign own_burst = m_hburst[3*addr_owner_q +: 3];
  assign HTRANS    = own_trans;
  assign HBURST    = own_burst;
  assign HADDR     = m_haddr[ADDR_W*addr_owner_q +: ADDR_W];
  assign HWRITE    = m_hwrite[addr_owner_q];
  assign HSIZE     = m_hsize[3*addr_owner_q +: 3];
  assign HWDATA    = m_hwdata[DATA_W*data_owner_q +: DATA_W];
  assign m_gnt     = N'(1) << addr_owner_q;
  assign m_hresp   = {N{HRESP & data_vld_q}} & (N'(1) << data_owner_q);
  assign m_hready  = HREADY;
  assign m_hrdata  = HRDATA;
`ifdef ARB_LOCK_EN
  logic locked_q;
  // lock follows the address-phase owner's HMASTLOCK at every accepted cycle
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) locked_q <= 1'b0;
    else if (HREADY) locked_q <= m_hmastlock[addr_owner_q];
  assign locked    = locked_q;
  assign HMASTLOCK = m_hmastlock[addr_owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^m_hmastlock;
  assign locked      = 1'b0;
  assign HMASTLOCK   = 1'b0;
`endif
  // switch points never fall inside a burst (SEQ/BUSY); IDLE or an exhausted SINGLE run releases the bus
  always_comb begin
    single_ns    = own_trans == NONSEQ && own_burst == SINGLE;
    sw           = HREADY && ((own_trans == IDLE && (!locked || !m_req[addr_owner_q])) ||
                              (single_ns && hold_cnt_q == HOLD_LAST && !locked));
    chg          = sw && pick_vld && nxt != addr_owner_q;
    addr_owner_d = chg ? nxt : addr_owner_q;
    hold_cnt_d   = chg ? '0 :
                   single_ns ? ((hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1) :
                   (own_trans == NONSEQ) ? '0 : hold_cnt_q;
  end
  // ownership and data-phase pipeline advance only on accepted cycles; wait states freeze everything
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
      data_vld_q   <= 1'b0;
      hold_cnt_q   <= '0;
    end else if (HREADY) begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= addr_owner_q;
      data_vld_q   <= own_trans[1];
      hold_cnt_q   <= hold_cnt_d;
    end
endmodule
